// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and the iteration count.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } mdu_state_e;

    localparam int MDU_ITER = 32;

    function automatic logic is_div(input logic [1:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [31:0] neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit: one shift-add or restoring
// divide step per cycle over 32 cycles, with sign correction on completion.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    // Handshake: start is only looked at while busy=0; busy rises on the edge
    // that accepts start and falls on the completion edge, which also raises
    // done for exactly one cycle with hi/lo/div_zero already updated.

    mdu_state_e state, state_nxt;

    logic        div_q;
    logic        neg_q;
    logic        neg_r;
    logic        dz_q;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opb;

    logic        a_neg;
    logic        b_neg;
    logic        req_div_zero;
    logic [32:0] mul_sum;
    logic [32:0] div_trial;
    logic [63:0] iter_acc;
    logic [63:0] prod_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_dz;

    assign a_neg        = is_signed_op(op) & srcA[31];
    assign b_neg        = is_signed_op(op) & srcB[31];
    assign req_div_zero = is_div(op) && (srcB == 32'd0);
    assign busy         = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = req_div_zero ? S_FINISH : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == 6'(MDU_ITER - 1)) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Multiply keeps {partial product, remaining multiplier} in acc; divide keeps
    // {partial remainder, remaining dividend / quotient bits} in acc.
    assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, opb};
    assign div_trial = acc[63:31] - {1'b0, opb};

    always_comb begin
        iter_acc = acc;
        if (div_q) begin
            if (div_trial[32]) begin
                iter_acc = {acc[62:0], 1'b0};
            end else begin
                iter_acc = {div_trial[31:0], acc[30:0], 1'b1};
            end
        end else begin
            if (acc[0]) begin
                iter_acc = {mul_sum, acc[31:1]};
            end else begin
                iter_acc = {1'b0, acc[63:32], acc[31:1]};
            end
        end
    end

    assign prod_fix = neg_q ? (~acc + 64'd1) : acc;

    // On divide-by-zero acc[31:0] carries the raw dividend, which becomes hi.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_dz = 1'b0;
        if (dz_q) begin
            res_hi = acc[31:0];
            res_lo = 32'hFFFF_FFFF;
            res_dz = 1'b1;
        end else if (div_q) begin
            res_hi = neg32(acc[63:32], neg_r);
            res_lo = neg32(acc[31:0], neg_q);
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz_q     <= 1'b0;
            cnt      <= 6'd0;
            acc      <= 64'd0;
            opb      <= 32'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            div_zero <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_q <= is_div(op);
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dz_q  <= req_div_zero;
                        cnt   <= 6'd0;
                        opb   <= neg32(srcB, b_neg);
                        if (req_div_zero) begin
                            acc <= {32'd0, srcA};
                        end else begin
                            acc <= {32'd0, neg32(srcA, a_neg)};
                        end
                    end
                end
                S_CALC: begin
                    acc <= iter_acc;
                    cnt <= cnt + 6'd1;
                end
                S_FINISH: begin
                    hi       <= res_hi;
                    lo       <= res_lo;
                    div_zero <= res_dz;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, reset abort and
// randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    // {div_zero, hi, lo}
    logic [64:0] exp_q[$];

    mult_div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .srcA     (srcA),
        .srcB     (srcB),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model from plain arithmetic
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        sa = $signed(a);
        sb = $signed(b);
        p = 64'd0;
        q = 32'd0;
        r = 32'd0;
        case (o)
            2'b00: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = a / b;
                r = a % b;
            end
        endcase
        return {1'b0, r, q};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // driver: issues one op, optionally pulses a junk start at busy cycle ign_at,
    // then checks latency, busy, hold of old results and the final result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int ign_at, input string tag);
        logic [64:0] e;
        logic [31:0] hi0;
        logic [31:0] lo0;
        int n;
        int lat_exp;
        exp_q.push_back(model(o, a, b));
        lat_exp = ((o[1] == 1'b1) && (b == 32'd0)) ? 1 : 33;
        hi0 = hi;
        lo0 = lo;
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        srcA  = $urandom;
        srcB  = $urandom;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 60) begin
            if (n == ign_at) begin
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
                srcA  = $urandom;
                srcB  = 32'd0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (n == 16 && !done) begin
                chk({tag, "_hold"}, {hi, lo}, {hi0, lo0});
            end
        end
        e = exp_q.pop_front();
        chk({tag, "_latency"}, 64'(n), 64'(lat_exp));
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_hilo"}, {hi, lo}, e[63:0]);
        chk({tag, "_dz"}, 64'(div_zero), 64'(e[64]));
    endtask

    initial begin
        int n;
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        srcA  = 32'd0;
        srcB  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");
        chk("mult_neg_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, "multu_max");
        chk("multu_max_lit", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
        chk("div_neg_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'd7, 32'd2, -1, "divu");
        chk("divu_lit", {hi, lo}, 64'h0000_0001_0000_0003);
        run_op(2'b11, 32'd7, 32'd0, -1, "divu_zero");
        chk("divu_zero_lit", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(2'b01, 32'd2, 32'd3, -1, "multu_after_dz");
        chk("multu_after_dz_lit", {hi, lo}, 64'd6);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        chk("div_ovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'b10, 32'h8000_0000, 32'd0, -1, "div_zero_s");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 5, "mult_minmin");
        run_op(2'b10, 32'd9, 32'hFFFF_FFFC, -1, "div_pos_neg");

        // reset in the middle of a multiply
        start = 1'b1;
        op    = 2'b00;
        srcA  = 32'h1234_5678;
        srcB  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("abort_no_done", 64'(n), 64'd0);
        run_op(2'b01, 32'd5, 32'd5, -1, "post_rst");
        chk("post_rst_lit", {hi, lo}, 64'd25);

        // randomized operations, issued back-to-back in the done cycle
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 15));
                2: r_a = 32'h8000_0000;
                3: r_b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(r_op, r_a, r_b, int'($urandom_range(0, 25)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
